// File: rtl/serial_pkg.sv
// serial_pkg: shared FSM states, line levels and parity helper for the serial receiver
package serial_pkg;
   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;
   localparam logic IDLE_LEVEL  = 1'b0;
   localparam logic START_LEVEL = 1'b1;
   function automatic logic even_parity(input logic [63:0] word);
      return ^word;
   endfunction
endpackage

// File: rtl/sipo_shift.sv
// sipo_shift: serial-in parallel-out register, new bits enter at the LSB
module sipo_shift #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         din,
   output logic [W-1:0] q
);
   // shift left on enable so the first bit received ends up as the MSB
   always_ff @(posedge clk) begin
      if (rst) q <= '0;
      else if (en) q <= {q[W-2:0], din};
   end
endmodule

// File: rtl/sipo_frame_rx.sv
// sipo_frame_rx: start/data/parity/stop frame receiver with a one-entry valid/ready output
module sipo_frame_rx
   import serial_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int PARITY_EN = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              serial_in,
   output logic [DATA_W-1:0] out_data,
   output logic              out_perr,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              frame_err,
   output logic              overrun
);
   localparam int CW = $clog2(DATA_W + 1);
   rx_state_t         state, state_n;
   logic [CW-1:0]     cnt, cnt_n;
   logic              shift_en, par_q, deliver, bad_stop, perr;
   logic [DATA_W-1:0] sh_q;

   sipo_shift #(.W(DATA_W)) u_shift (
      .clk (clk),
      .rst (rst),
      .en  (shift_en),
      .din (serial_in),
      .q   (sh_q)
   );

   assign deliver  = (state == STOP) && (serial_in == IDLE_LEVEL);
   assign bad_stop = (state == STOP) && (serial_in != IDLE_LEVEL);
   assign perr     = (PARITY_EN != 0) ? even_parity(64'({sh_q, par_q})) : 1'b0;

   // next-state and bit counting: DATA runs for DATA_W edges, then optional parity, then stop
   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      shift_en = 1'b0;
      case (state)
         IDLE: begin
            if (serial_in == START_LEVEL) begin
               state_n = DATA;
               cnt_n   = '0;
            end
         end
         DATA: begin
            shift_en = 1'b1;
            cnt_n    = cnt + CW'(1);
            if (cnt == CW'(DATA_W - 1)) state_n = (PARITY_EN != 0) ? PARITY : STOP;
         end
         PARITY:  state_n = STOP;
         STOP:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // state, counter and captured parity bit
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         par_q <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         if (state == PARITY) par_q <= serial_in;
      end
   end

   // output register: load on a good stop if empty or draining, else flag overrun
   always_ff @(posedge clk) begin
      if (rst) begin
         out_data  <= '0;
         out_perr  <= 1'b0;
         out_valid <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= bad_stop;
         overrun   <= deliver && out_valid && !out_ready;
         if (deliver && (!out_valid || out_ready)) begin
            out_data  <= sh_q;
            out_perr  <= perr;
            out_valid <= 1'b1;
         end else if (out_valid && out_ready && !deliver) begin
            out_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_sipo_frame_rx.sv
// tb_sipo_frame_rx: directed and randomized frames checked against a frame-level model
module tb_sipo_frame_rx;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       serial_in = 1'b0, out_ready = 1'b0;
   logic [7:0] out_data;
   logic       out_perr, out_valid, frame_err, overrun;
   logic       si0 = 1'b0, rdy0 = 1'b0;
   logic [7:0] data0;
   logic       perr0, valid0, fe0, ov0;
   int         checks = 0, errors = 0;
   logic       m_valid = 1'b0, m_perr = 1'b0;
   logic [7:0] m_data = 8'h00;

   always #5 clk = ~clk;

   sipo_frame_rx #(.DATA_W(8), .PARITY_EN(1)) dut (
      .clk(clk), .rst(rst), .serial_in(serial_in), .out_data(out_data), .out_perr(out_perr),
      .out_valid(out_valid), .out_ready(out_ready), .frame_err(frame_err), .overrun(overrun)
   );

   sipo_frame_rx #(.DATA_W(8), .PARITY_EN(0)) dut0 (
      .clk(clk), .rst(rst), .serial_in(si0), .out_data(data0), .out_perr(perr0),
      .out_valid(valid0), .out_ready(rdy0), .frame_err(fe0), .overrun(ov0)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic rv(input int mode);
      return (mode == 2) ? logic'($urandom % 2) : logic'(mode);
   endfunction

   // one clock of the parity-enabled receiver; the model decides outcomes at the frame level
   task automatic tick(input logic s, input logic r, input bit stop, input logic [7:0] d, input logic p);
      logic ef, eo;
      ef = 1'b0;
      eo = 1'b0;
      if (stop && s) begin
         ef = 1'b1;
         if (m_valid && r) m_valid = 1'b0;
      end else if (stop) begin
         if (!m_valid || r) begin
            m_valid = 1'b1;
            m_data  = d;
            m_perr  = ^{d, p};
         end else eo = 1'b1;
      end else if (m_valid && r) m_valid = 1'b0;
      serial_in = s;
      out_ready = r;
      @(posedge clk);
      #1;
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("out_data", 32'(out_data), 32'(m_data));
      chk("out_perr", 32'(out_perr), 32'(m_perr));
      chk("frame_err", 32'(frame_err), 32'(ef));
      chk("overrun", 32'(overrun), 32'(eo));
   endtask

   task automatic send(input logic [7:0] d, input logic p, input logic stp, input int rmode, input logic rs);
      tick(1'b1, rv(rmode), 0, d, p);
      for (int i = 7; i >= 0; i--) tick(d[i], rv(rmode), 0, d, p);
      tick(p, rv(rmode), 0, d, p);
      tick(stp, rs, 1, d, p);
   endtask

   task automatic idle(input int n, input int rmode);
      for (int i = 0; i < n; i++) tick(1'b0, rv(rmode), 0, 8'h00, 1'b0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         serial_in = logic'($urandom % 2);
         out_ready = logic'($urandom % 2);
         @(posedge clk);
      end
      #1;
      m_valid = 1'b0;
      m_data  = 8'h00;
      m_perr  = 1'b0;
      chk("rst_valid", 32'(out_valid), 32'(0));
      chk("rst_data", 32'(out_data), 32'(0));
      chk("rst_perr", 32'(out_perr), 32'(0));
      chk("rst_ferr", 32'(frame_err), 32'(0));
      chk("rst_ovr", 32'(overrun), 32'(0));
      chk("rst_valid0", 32'(valid0), 32'(0));
      serial_in = 1'b0;
      rst = 1'b0;
   endtask

   task automatic tick0(input logic s);
      si0 = s;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] d;
      do_reset();
      send(8'hA5, 1'b0, 1'b0, 1, 1'b1);
      idle(2, 1);
      send(8'h81, 1'b1, 1'b0, 1, 1'b1);
      idle(1, 1);
      send(8'h3C, 1'b0, 1'b1, 1, 1'b1);
      send(8'h0F, 1'b0, 1'b0, 1, 1'b1);
      idle(1, 1);
      send(8'h11, 1'b0, 1'b0, 0, 1'b0);
      send(8'h22, 1'b0, 1'b0, 0, 1'b0);
      idle(2, 0);
      idle(1, 1);
      send(8'h11, 1'b0, 1'b0, 0, 1'b0);
      send(8'h22, 1'b0, 1'b0, 0, 1'b1);
      idle(1, 1);
      d = 8'h96;
      tick(1'b1, 1'b0, 0, d, 1'b0);
      for (int i = 7; i >= 4; i--) tick(d[i], 1'b0, 0, d, 1'b0);
      do_reset();
      send(8'hC3, 1'b0, 1'b0, 1, 1'b1);
      idle(1, 1);
      for (int f = 0; f < 40; f++) begin
         send(8'($urandom), logic'($urandom % 2), logic'(($urandom % 8) == 0), 2, logic'($urandom % 2));
         idle(int'($urandom % 3), 2);
      end
      out_ready = 1'b0;
      d = 8'h5A;
      tick0(1'b1);
      for (int i = 7; i >= 1; i--) tick0(d[i]);
      chk("np_valid_early", 32'(valid0), 32'(0));
      tick0(d[0]);
      tick0(1'b0);
      chk("np_valid", 32'(valid0), 32'(1));
      chk("np_data", 32'(data0), 32'(8'h5A));
      chk("np_perr", 32'(perr0), 32'(0));
      chk("np_ferr", 32'(fe0), 32'(0));
      rdy0 = 1'b1;
      d = 8'h33;
      tick0(1'b1);
      for (int i = 7; i >= 0; i--) tick0(d[i]);
      tick0(1'b1);
      chk("np_ferr_pulse", 32'(fe0), 32'(1));
      chk("np_valid_drained", 32'(valid0), 32'(0));
      tick0(1'b0);
      chk("np_ferr_clear", 32'(fe0), 32'(0));
      chk("np_ovr", 32'(ov0), 32'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
